// File: rtl/src_pingpong_buf.sv
// Purpose: two-bank ping-pong buffer, LANES-wide write beats in, single-word indexed reads out.
// Latency: read data is registered and appears one cycle after an accepted exec.
// Backpressure: src_rdy low while the write bank is full (beats dropped, ovf set); exec_rdy low while the read bank is empty.
//
// Ports:
//   clk, reset                      rising-edge clock, synchronous active-high reset
//   src_v, src_a, src_d, src_last   write beat: all LANES words to word src_a of bank wp; src_last commits the bank
//   src_rdy                         write bank is free
//   exec, ia                        read request: lane ia[LB-1:0], word ia[IA-1:LB] of bank rp
//   rd_done                         release the read bank
//   exec_rdy                        read bank is full
//   d, d_v                          registered read data and its update strobe
//   nfull, ovf                      number of full banks, sticky dropped-write flag
module src_pingpong_buf #(
    parameter  int DW    = 16,
    parameter  int LANES = 4,
    parameter  int DEPTH = 1024,
    localparam int LB    = $clog2(LANES),
    localparam int WB    = $clog2(DEPTH),
    localparam int IA    = WB + LB
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                src_v,
    input  logic [WB-1:0]       src_a,
    input  logic [LANES*DW-1:0] src_d,
    input  logic                src_last,
    output logic                src_rdy,
    input  logic                exec,
    input  logic [IA-1:0]       ia,
    input  logic                rd_done,
    output logic                exec_rdy,
    output logic [DW-1:0]       d,
    output logic                d_v,
    output logic [1:0]          nfull,
    output logic                ovf
);

    // One memory per lane; the bank number is the top address bit.
    logic [DW-1:0] mem [0:LANES-1][0:2*DEPTH-1];

    logic [1:0]    full;
    logic [1:0]    full_nxt;
    logic          wp;
    logic          rp;

    logic          wr_acc;
    logic          commit;
    logic          rd_acc;
    logic          rel;
    logic [LB-1:0] rd_lane;
    logic [WB-1:0] rd_word;

    assign src_rdy  = ~full[wp];
    assign exec_rdy = full[rp];
    assign nfull    = {1'b0, full[0]} + {1'b0, full[1]};

    // Reset overrides every same-cycle request, including memory writes.
    assign wr_acc  = ~reset & src_v & src_rdy;
    assign commit  = wr_acc & src_last;
    assign rd_acc  = exec & exec_rdy;
    assign rel     = rd_done & exec_rdy;
    assign rd_lane = ia[LB-1:0];
    assign rd_word = ia[IA-1:LB];

    // A commit needs full[wp]=0 and a release needs full[rp]=1, so when both
    // happen in one cycle they always touch different banks.
    always_comb begin
        full_nxt = full;
        if (commit) full_nxt[wp] = 1'b1;
        if (rel)    full_nxt[rp] = 1'b0;
    end

    // Memory has no reset: contents survive a reset untouched.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int k = 0; k < LANES; k++) begin
                mem[k][{wp, src_a}] <= src_d[k*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 2'b00;
            wp   <= 1'b0;
            rp   <= 1'b0;
            d    <= '0;
            d_v  <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            full <= full_nxt;
            if (commit) wp <= ~wp;
            // Read uses the pre-release rp, so exec+rd_done reads the old bank.
            if (rel) rp <= ~rp;
            if (src_v & ~src_rdy) ovf <= 1'b1;
            d_v <= rd_acc;
            if (rd_acc) d <= mem[rd_lane][{rp, rd_word}];
        end
    end

endmodule

// File: tb/tb_src_pingpong_buf.sv
module tb_src_pingpong_buf;

    localparam int DW    = 16;
    localparam int LANES = 4;
    localparam int DEPTH = 1024;
    localparam int LB    = 2;
    localparam int WB    = 10;
    localparam int IA    = 12;

    logic                clk = 1'b0;
    logic                reset;
    logic                src_v;
    logic [WB-1:0]       src_a;
    logic [LANES*DW-1:0] src_d;
    logic                src_last;
    logic                src_rdy;
    logic                exec;
    logic [IA-1:0]       ia;
    logic                rd_done;
    logic                exec_rdy;
    logic [DW-1:0]       d;
    logic                d_v;
    logic [1:0]          nfull;
    logic                ovf;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    src_pingpong_buf #(.DW(DW), .LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .src_v    (src_v),
        .src_a    (src_a),
        .src_d    (src_d),
        .src_last (src_last),
        .src_rdy  (src_rdy),
        .exec     (exec),
        .ia       (ia),
        .rd_done  (rd_done),
        .exec_rdy (exec_rdy),
        .d        (d),
        .d_v      (d_v),
        .nfull    (nfull),
        .ovf      (ovf)
    );

    typedef struct {
        logic [IA-1:0] ia;
        logic [DW-1:0] exp;
    } rd_vec_t;

    rd_vec_t tbl [8];

    // Word pattern: generation gen, lane k, word w.
    function automatic logic [DW-1:0] pat(int gen, int k, int w);
        return DW'(gen * 10000 + k * 1000 + w);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset    = 1'b0;
        src_v    = 1'b0;
        src_a    = '0;
        src_d    = '0;
        src_last = 1'b0;
        exec     = 1'b0;
        ia       = '0;
        rd_done  = 1'b0;
    endtask

    task automatic set_beat(int gen, int w, logic last);
        src_v    = 1'b1;
        src_a    = WB'(w);
        src_last = last;
        for (int k = 0; k < LANES; k++) src_d[k*DW +: DW] = pat(gen, k, w);
    endtask

    // Writes words 0..n-1; commits on the last one when commit_last is set.
    task automatic fill(int gen, int n, logic commit_last);
        for (int w = 0; w < n; w++) begin
            set_beat(gen, w, commit_last && (w == n - 1));
            cyc();
        end
        src_v    = 1'b0;
        src_last = 1'b0;
    endtask

    task automatic check_status(string tag, int e_nfull, logic e_srdy, logic e_erdy, logic e_ovf);
        check({tag, ".nfull"},    32'(nfull),    32'(e_nfull));
        check({tag, ".src_rdy"},  32'(src_rdy),  32'(e_srdy));
        check({tag, ".exec_rdy"}, 32'(exec_rdy), 32'(e_erdy));
        check({tag, ".ovf"},      32'(ovf),      32'(e_ovf));
    endtask

    task automatic read_check(string tag, logic [IA-1:0] idx, logic [DW-1:0] e_d);
        exec = 1'b1;
        ia   = idx;
        cyc();
        exec = 1'b0;
        check({tag, ".d"},   32'(d),   32'(e_d));
        check({tag, ".d_v"}, 32'(d_v), 32'd1);
    endtask

    initial begin
        // Bank-0 generation-0 reads: ia = 4*word + lane, value = lane*1000 + word.
        tbl[0] = '{ia: 12'd22,   exp: 16'd2005};
        tbl[1] = '{ia: 12'd0,    exp: 16'd0};
        tbl[2] = '{ia: 12'd3,    exp: 16'd3000};
        tbl[3] = '{ia: 12'd4095, exp: 16'd4023};
        tbl[4] = '{ia: 12'd401,  exp: 16'd1100};
        tbl[5] = '{ia: 12'd2050, exp: 16'd2512};
        tbl[6] = '{ia: 12'd4,    exp: 16'd1};
        tbl[7] = '{ia: 12'd4092, exp: 16'd1023};

        idle();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        check_status("rst", 0, 1'b1, 1'b0, 1'b0);
        check("rst.d",   32'(d),   32'd0);
        check("rst.d_v", 32'(d_v), 32'd0);

        // exec with no full bank: no read, d holds.
        exec = 1'b1;
        ia   = 12'd22;
        cyc();
        exec = 1'b0;
        check("empty_exec.d_v", 32'(d_v), 32'd0);
        check("empty_exec.d",   32'(d),   32'd0);

        // Fill bank 0 with generation 0.
        fill(0, DEPTH, 1'b1);
        check_status("fill0", 1, 1'b1, 1'b1, 1'b0);
        read_check("rd2005", 12'd22, 16'd2005);
        cyc();
        check("hold.d_v", 32'(d_v), 32'd0);
        check("hold.d",   32'(d),   32'd2005);

        // Fill bank 1 while reading bank 0 every cycle.
        for (int c = 0; c < DEPTH; c++) begin
            set_beat(1, c, c == DEPTH - 1);
            exec = 1'b1;
            ia   = tbl[c % 8].ia;
            cyc();
            check($sformatf("conc%0d.d_v", c), 32'(d_v), 32'd1);
            check($sformatf("conc%0d.d", c),   32'(d),   32'(tbl[c % 8].exp));
        end
        idle();
        check_status("both_full", 2, 1'b0, 1'b1, 1'b0);

        // Write to a full bank is dropped and flags ovf.
        set_beat(5, 5, 1'b1);
        cyc();
        idle();
        check_status("ovf", 2, 1'b0, 1'b1, 1'b1);
        read_check("b0_no_write", 12'd20, 16'd5);

        // exec + rd_done together: read old bank, then release it.
        exec    = 1'b1;
        ia      = 12'd22;
        rd_done = 1'b1;
        cyc();
        idle();
        check("exec_rel.d",   32'(d),   32'd2005);
        check("exec_rel.d_v", 32'(d_v), 32'd1);
        check_status("exec_rel", 1, 1'b1, 1'b1, 1'b1);
        read_check("rp1",          12'd22, 16'd12005);
        read_check("b1_no_write",  12'd20, 16'd10005);

        // Commit bank 0 and release bank 1 in the same cycle.
        fill(2, DEPTH - 1, 1'b0);
        check_status("pre_cr", 1, 1'b1, 1'b1, 1'b1);
        set_beat(2, DEPTH - 1, 1'b1);
        rd_done = 1'b1;
        cyc();
        idle();
        check_status("commit_rel", 1, 1'b1, 1'b1, 1'b1);
        read_check("rp0", 12'd22, 16'd22005);

        // Fill bank 1 again, then reset with everything active.
        fill(3, DEPTH, 1'b1);
        check_status("pre_rst", 2, 1'b0, 1'b1, 1'b1);
        reset   = 1'b1;
        exec    = 1'b1;
        ia      = 12'd22;
        rd_done = 1'b1;
        set_beat(4, 3, 1'b1);
        cyc();
        idle();
        check_status("mid_rst", 0, 1'b1, 1'b0, 1'b0);
        check("mid_rst.d",   32'(d),   32'd0);
        check("mid_rst.d_v", 32'(d_v), 32'd0);

        // rd_done/exec with nothing full are ignored.
        exec    = 1'b1;
        rd_done = 1'b1;
        cyc();
        idle();
        check_status("ign_rel", 0, 1'b1, 1'b0, 1'b0);
        check("ign_rel.d_v", 32'(d_v), 32'd0);

        // One-beat commit of bank 0: other words keep pre-reset contents.
        set_beat(4, 0, 1'b1);
        cyc();
        idle();
        check_status("one_beat", 1, 1'b1, 1'b1, 1'b0);
        read_check("mem_kept", 12'd29, 16'd21007);
        read_check("new_word", 12'd2,  16'd42000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
